// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher feeding the Fetch stage through a PC-tagged FIFO.
// Define PREFETCH_BYPASS_EN to forward a response straight to the outputs when the queue is empty.
module instr_prefetch_queue #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              stall_F,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  req_pc;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [DATA_W-1:0]  fifo_data [DEPTH];
  logic [ADDR_W-1:0]  fifo_pc   [DEPTH];

  logic req_accept, push, pop, bypass, fifo_nonempty;

  assign fifo_nonempty = (count != '0);
  assign req_accept    = mem_req_valid & mem_req_ready;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = reset & ~fifo_nonempty & (state == S_WAIT) & mem_rsp_valid & ~redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word consumed this cycle must not also land in the FIFO.
  assign push = (state == S_WAIT) & mem_rsp_valid & ~redirect_valid & ~(bypass & ~stall_F);
  assign pop  = fifo_nonempty & ~stall_F & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // A response landing in the redirect cycle retires the outstanding request, so no drain is needed.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH: if (req_accept)         state_nxt = redirect_valid ? S_DRAIN : S_WAIT;
      S_WAIT:  if (mem_rsp_valid)      state_nxt = S_FETCH;
               else if (redirect_valid) state_nxt = S_DRAIN;
      S_DRAIN: if (mem_rsp_valid)      state_nxt = S_FETCH;
      default:                         state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_valid = reset & (state == S_FETCH) & (count < CNT_W'(DEPTH));
    mem_req_addr  = fetch_pc;
    instr_valid   = (reset & fifo_nonempty) | bypass;
    instr         = '0;
    instr_pc      = '0;
    if (bypass) begin
      instr    = mem_rsp_data;
      instr_pc = req_pc;
    end else if (fifo_nonempty) begin
      instr    = fifo_data[rd_ptr];
      instr_pc = fifo_pc[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (req_accept) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
        req_pc   <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      fifo_data[wr_ptr] <= mem_rsp_data;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a one-cycle-latency memory model.
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        stall_F;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  logic auto_rsp;

  instr_prefetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .stall_F(stall_F),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Samples the handshake mid-cycle, then answers one cycle later when auto_rsp is set.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    @(negedge clk);
    acc = mem_req_valid && mem_req_ready;
    a   = mem_req_addr;
    if (acc) n_acc++;
    @(posedge clk);
    #1;
    mem_rsp_valid = auto_rsp && acc;
    mem_rsp_data  = (auto_rsp && acc) ? data_of(a) : 32'h0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_acc = 0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_i, ins_i;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    stall_F = 1'b0; auto_rsp = 1'b1;

    // Reset behaviour and in-order streaming
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ivalid", {31'b0, instr_valid}, 32'd0);
      check("rst_reqv", {31'b0, mem_req_valid}, 32'd0);
    end
    check("rst_instr", instr, 32'h0);
    check("rst_ipc", instr_pc, 32'h0);
    reset = 1'b1; #1;
    check("c0_reqv", {31'b0, mem_req_valid}, 32'd1);
    check("c0_addr", mem_req_addr, 32'h0);
    req_i = 0; ins_i = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_req_valid && mem_req_ready) begin
        if (req_i < 3) check("seq_addr", mem_req_addr, 32'(req_i * 4));
        req_i++;
      end
      if (instr_valid) begin
        if (ins_i < 3) begin
          check("seq_ipc", instr_pc, 32'(ins_i * 4));
          check("seq_data", instr, data_of(32'(ins_i * 4)));
        end
        ins_i++;
      end
      if (c == 1) check("first_valid_c2", {31'b0, instr_valid}, 32'd0);
      if (c == 2) check("first_valid_c2", {31'b0, instr_valid}, 32'd1);
      tick();
    end
    check("seq_nreq", 32'(req_i >= 3), 32'd1);
    check("seq_nins", 32'(ins_i >= 3), 32'd1);

    // Stall fills exactly DEPTH entries, then drains in order
    stall_F = 1'b1;
    do_reset();
    for (int c = 0; c < 20; c++) tick();
    check("stall_nacc", 32'(n_acc), 32'd4);
    check("stall_reqv", {31'b0, mem_req_valid}, 32'd0);
    stall_F = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {31'b0, instr_valid}, 32'd1);
      check("drain_ipc", instr_pc, 32'(i * 4));
      check("drain_data", instr, data_of(32'(i * 4)));
      if (i == 1) begin
        check("refill_reqv", {31'b0, mem_req_valid}, 32'd1);
        check("refill_addr", mem_req_addr, 32'h10);
      end
      tick();
    end

    // Redirect while waiting; the in-flight response is dropped in DRAIN
    stall_F = 1'b1; auto_rsp = 1'b0;
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    tick();
    redirect_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000DEAD; #1;
    check("drain_reqv", {31'b0, mem_req_valid}, 32'd0);
    check("drain_ivalid", {31'b0, instr_valid}, 32'd0);
    tick();
    check("redir_ivalid", {31'b0, instr_valid}, 32'd0);
    check("redir_reqv", {31'b0, mem_req_valid}, 32'd1);
    check("redir_addr", mem_req_addr, 32'h100);
    auto_rsp = 1'b1;
    tick();
`ifndef PREFETCH_BYPASS_EN
    check("redir_rsp_cycle", {31'b0, instr_valid}, 32'd0);
`endif
    tick();
    check("redir_ivalid2", {31'b0, instr_valid}, 32'd1);
    check("redir_ipc", instr_pc, 32'h100);
    check("redir_data", instr, data_of(32'h100));

    // Redirect coinciding with a pop at count=3
    stall_F = 1'b1;
    do_reset();
    for (int c = 0; c < 6; c++) tick();
    check("cnt3_ipc", instr_pc, 32'h0);
    check("cnt3_addr", mem_req_addr, 32'hC);
    stall_F = 1'b0; mem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
    tick();
    check("flush_ivalid", {31'b0, instr_valid}, 32'd0);
    check("flush_reqv", {31'b0, mem_req_valid}, 32'd1);
    check("flush_addr", mem_req_addr, 32'h200);

    // Address wrap at the top of the space
    redirect_pc = 32'hFFFF_FFFC; #1;
    tick();
    redirect_valid = 1'b0; mem_req_ready = 1'b1; stall_F = 1'b1; #1;
    check("wrap_addr0", mem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("wrap_reqv", {31'b0, mem_req_valid}, 32'd1);
    check("wrap_addr", mem_req_addr, 32'h0);
    check("wrap_ipc", instr_pc, 32'hFFFF_FFFC);

    // Empty-queue response timing
    stall_F = 1'b0;
    do_reset();
    tick();
`ifdef PREFETCH_BYPASS_EN
    check("byp_valid", {31'b0, instr_valid}, 32'd1);
    check("byp_ipc", instr_pc, 32'h0);
    check("byp_data", instr, data_of(32'h0));
    tick();
    check("byp_cnt0", {31'b0, instr_valid}, 32'd0);
`else
    check("nobyp_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    check("nobyp_valid2", {31'b0, instr_valid}, 32'd1);
    check("nobyp_ipc", instr_pc, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
